rf_wb_arbiter: RTL and testbench

- Write-port arbiter and scoreboard for the 32x32 integer register file.
- Shares the file's single write port (we_reg_W / rd_W / Wdata) between three sources:
  - main pipeline W stage;
  - load unit (LU);
  - multi-cycle mul/div unit (MD).
- Tracks destination registers of in-flight long-latency ops and raises a decode-stage stall on RAW/WAW hazards against them.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/rf_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register-file write-back path.
package rf_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] X0 = '0;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_PIPE = 2'd1,
        WB_LU   = 2'd2,
        WB_MD   = 2'd3
    } wb_src_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for destinations of in-flight long-latency ops.
// Produces the decode-stage hazard stall; x0 is never busy.
module rf_scoreboard #(
    parameter int unsigned AW = rf_pkg::REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    output logic          stall
);
    import rf_pkg::*;

    localparam int unsigned NREGS = 1 << AW;

    logic [NREGS-1:0] busy_q, busy_d;

    // Clear is applied first so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookups use the registered bits only: a register cleared this cycle still stalls.
    always_comb begin
        stall = 1'b0;
        if ((rs1 != '0) && busy_q[rs1]) stall = 1'b1;
        if ((rs2 != '0) && busy_q[rs2]) stall = 1'b1;
        if ((rd  != '0) && busy_q[rd])  stall = 1'b1;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (pipeline / load unit / mul-div) with hazard scoreboard.
// Define RF_WB_STARVE_EN to enable secondary wait counters and the pipe_hold anti-starvation path.
module rf_wb_arbiter #(
    parameter int unsigned XLEN     = rf_pkg::XLEN,
    parameter int unsigned REG_AW   = rf_pkg::REG_AW,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_we_W,
    input  logic [REG_AW-1:0] pipe_rd_W,
    input  logic [XLEN-1:0]   pipe_wdata_W,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_wdata,
    output logic              lu_ready,
    input  logic              md_valid,
    input  logic [REG_AW-1:0] md_rd,
    input  logic [XLEN-1:0]   md_wdata,
    output logic              md_ready,
    input  logic              issue_long,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rd_D,
    output logic              stall_D,
    output logic              pipe_hold,
    output logic              we_reg_W,
    output logic [REG_AW-1:0] rd_W,
    output logic [XLEN-1:0]   Wdata,
    output logic [1:0]        wb_src_W
);
    import rf_pkg::*;

    logic    slot_taken;
    logic    lu_grant, md_grant;
    logic    lu_starved, md_starved;
    logic    rr_q, rr_d;  // 0: LU preferred, 1: MD preferred
    logic    hold_q;
    wb_src_t wb_src;

`ifdef RF_WB_STARVE_EN
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [7:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       hold_d;

    assign lu_starved = hold_q & lu_valid & (lu_cnt_q == WAIT_LIM);
    assign md_starved = hold_q & md_valid & (md_cnt_q == WAIT_LIM);

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (!lu_valid || lu_grant) begin
            lu_cnt_d = '0;
        end else if (lu_cnt_q != WAIT_LIM) begin
            lu_cnt_d = lu_cnt_q + 8'd1;
        end

        md_cnt_d = md_cnt_q;
        if (!md_valid || md_grant) begin
            md_cnt_d = '0;
        end else if (md_cnt_q != WAIT_LIM) begin
            md_cnt_d = md_cnt_q + 8'd1;
        end

        // One-cycle hold, never back-to-back; a still-saturated counter re-arms after the gap.
        hold_d = !hold_q && ((lu_cnt_d == WAIT_LIM) || (md_cnt_d == WAIT_LIM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            md_cnt_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            md_cnt_q <= md_cnt_d;
            hold_q   <= hold_d;
        end
    end
`else
    logic unused_max_wait;

    assign unused_max_wait = ^MAX_WAIT;
    assign hold_q          = 1'b0;
    assign lu_starved      = 1'b0;
    assign md_starved      = 1'b0;
`endif

    // The pipeline owns the slot unless it is held or writing x0.
    always_comb begin
        slot_taken = rst_n && pipe_we_W && (pipe_rd_W != '0) && !hold_q;
        lu_grant   = 1'b0;
        md_grant   = 1'b0;
        if (rst_n && !slot_taken) begin
            if (lu_starved) begin
                lu_grant = 1'b1;
            end else if (md_starved) begin
                md_grant = 1'b1;
            end else if (lu_valid && md_valid) begin
                lu_grant = !rr_q;
                md_grant = rr_q;
            end else begin
                lu_grant = lu_valid;
                md_grant = md_valid;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (lu_grant) begin
            rr_d = 1'b1;
        end else if (md_grant) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        we_reg_W = 1'b0;
        rd_W     = '0;
        Wdata    = '0;
        wb_src   = WB_NONE;
        if (slot_taken) begin
            we_reg_W = 1'b1;
            rd_W     = pipe_rd_W;
            Wdata    = pipe_wdata_W;
            wb_src   = WB_PIPE;
        end else if (lu_grant) begin
            we_reg_W = (lu_rd != '0);
            rd_W     = lu_rd;
            Wdata    = lu_wdata;
            wb_src   = WB_LU;
        end else if (md_grant) begin
            we_reg_W = (md_rd != '0);
            rd_W     = md_rd;
            Wdata    = md_wdata;
            wb_src   = WB_MD;
        end
    end

    assign lu_ready  = lu_grant;
    assign md_ready  = md_grant;
    assign pipe_hold = hold_q;
    assign wb_src_W  = wb_src;

    rf_scoreboard #(
        .AW (REG_AW)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (issue_long),
        .set_rd (issue_rd),
        .clr_en (lu_grant | md_grant),
        .clr_rd (lu_grant ? lu_rd : md_rd),
        .rs1    (rs1_D),
        .rs2    (rs2_D),
        .rd     (rd_D),
        .stall  (stall_D)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the write-port rules.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int unsigned MW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we_W;
    logic [4:0]  pipe_rd_W;
    logic [31:0] pipe_wdata_W;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_wdata;
    logic        md_ready;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic        stall_D, pipe_hold, we_reg_W;
    logic [4:0]  rd_W;
    logic [31:0] Wdata;
    logic [1:0]  wb_src_W;

    rf_wb_arbiter #(
        .XLEN     (32),
        .REG_AW   (5),
        .MAX_WAIT (MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_we_W    (pipe_we_W),
        .pipe_rd_W    (pipe_rd_W),
        .pipe_wdata_W (pipe_wdata_W),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_wdata     (lu_wdata),
        .lu_ready     (lu_ready),
        .md_valid     (md_valid),
        .md_rd        (md_rd),
        .md_wdata     (md_wdata),
        .md_ready     (md_ready),
        .issue_long   (issue_long),
        .issue_rd     (issue_rd),
        .rs1_D        (rs1_D),
        .rs2_D        (rs2_D),
        .rd_D         (rd_D),
        .stall_D      (stall_D),
        .pipe_hold    (pipe_hold),
        .we_reg_W     (we_reg_W),
        .rd_W         (rd_W),
        .Wdata        (Wdata),
        .wb_src_W     (wb_src_W)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state (committed at posedge) and next-state (computed at negedge).
    bit [31:0] m_busy, n_busy;
    int        m_lu_wait, m_md_wait, n_lu_wait, n_md_wait;
    bit        m_hold, n_hold, m_rr, n_rr;
    bit        e_lu, e_md, last_lu, last_md;

    always @(negedge clk) begin : cmp
        bit          slot, lu_st, md_st, g_lu, g_md, x_we, x_stall;
        int          x_src;
        logic [4:0]  x_rd;
        logic [31:0] x_data;
        if (!rst_n) begin
            chk("rst_we", {31'b0, we_reg_W}, 0);
            chk("rst_lu_ready", {31'b0, lu_ready}, 0);
            chk("rst_md_ready", {31'b0, md_ready}, 0);
            chk("rst_stall", {31'b0, stall_D}, 0);
            chk("rst_hold", {31'b0, pipe_hold}, 0);
            chk("rst_src", {30'b0, wb_src_W}, 0);
            n_busy = '0; n_lu_wait = 0; n_md_wait = 0; n_hold = 0; n_rr = 0;
            e_lu = 0; e_md = 0;
        end else begin
            slot  = pipe_we_W && (pipe_rd_W != 0) && !m_hold;
            lu_st = m_hold && lu_valid && (m_lu_wait >= MW);
            md_st = m_hold && md_valid && (m_md_wait >= MW);
            g_lu = 0;
            g_md = 0;
            if (!slot) begin
                if (lu_st) g_lu = 1;
                else if (md_st) g_md = 1;
                else if (lu_valid && md_valid) begin
                    if (m_rr) g_md = 1; else g_lu = 1;
                end else begin
                    g_lu = lu_valid;
                    g_md = md_valid;
                end
            end
            x_we = 0; x_rd = 0; x_data = 0; x_src = 0;
            if (slot) begin
                x_we = 1; x_rd = pipe_rd_W; x_data = pipe_wdata_W; x_src = 1;
            end else if (g_lu) begin
                x_we = (lu_rd != 0); x_rd = lu_rd; x_data = lu_wdata; x_src = 2;
            end else if (g_md) begin
                x_we = (md_rd != 0); x_rd = md_rd; x_data = md_wdata; x_src = 3;
            end
            x_stall = (rs1_D != 0 && m_busy[rs1_D]) || (rs2_D != 0 && m_busy[rs2_D]) ||
                      (rd_D != 0 && m_busy[rd_D]);
            chk("we_reg_W", {31'b0, we_reg_W}, {31'b0, x_we});
            chk("wb_src_W", {30'b0, wb_src_W}, x_src);
            chk("lu_ready", {31'b0, lu_ready}, {31'b0, g_lu});
            chk("md_ready", {31'b0, md_ready}, {31'b0, g_md});
            chk("stall_D", {31'b0, stall_D}, {31'b0, x_stall});
            chk("pipe_hold", {31'b0, pipe_hold}, {31'b0, m_hold});
            if (x_we) begin
                chk("rd_W", {27'b0, rd_W}, {27'b0, x_rd});
                chk("Wdata", Wdata, x_data);
            end
            if (slot && m_busy[pipe_rd_W]) chk("pipe_write_busy", 1, 0);
            n_busy = m_busy;
            if (g_lu) n_busy[lu_rd] = 0;
            if (g_md) n_busy[md_rd] = 0;
            if (issue_long && issue_rd != 0) n_busy[issue_rd] = 1;
            n_rr = g_lu ? 1'b1 : (g_md ? 1'b0 : m_rr);
`ifdef RF_WB_STARVE_EN
            n_lu_wait = (lu_valid && !g_lu) ? m_lu_wait + 1 : 0;
            n_md_wait = (md_valid && !g_md) ? m_md_wait + 1 : 0;
            n_hold = !m_hold && ((n_lu_wait >= MW) || (n_md_wait >= MW));
`else
            n_lu_wait = 0;
            n_md_wait = 0;
            n_hold = 0;
`endif
            e_lu = g_lu;
            e_md = g_md;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= '0; m_lu_wait <= 0; m_md_wait <= 0; m_hold <= 0; m_rr <= 0;
            last_lu <= 0; last_md <= 0;
        end else begin
            m_busy <= n_busy; m_lu_wait <= n_lu_wait; m_md_wait <= n_md_wait;
            m_hold <= n_hold; m_rr <= n_rr;
            last_lu <= e_lu; last_md <= e_md;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pipe_we_W = 0; pipe_rd_W = 0; pipe_wdata_W = 0;
        lu_valid = 0; lu_rd = 0; lu_wdata = 0;
        md_valid = 0; md_rd = 0; md_wdata = 0;
        issue_long = 0; issue_rd = 0;
        rs1_D = 0; rs2_D = 0; rd_D = 0;
    endtask

    task automatic drive_random(input int c);
        int r;
        if (!m_hold) begin
            pipe_we_W = ($urandom_range(99) < ((c < 1500) ? 90 : 50));
            r = $urandom_range(31);
            for (int t = 0; t < 8 && m_busy[r]; t++) r = $urandom_range(31);
            if (m_busy[r]) r = 0;
            pipe_rd_W = 5'(r);
            pipe_wdata_W = $urandom;
        end
        if (!lu_valid || last_lu) begin
            lu_valid = ($urandom_range(99) < 40);
            lu_rd = 5'($urandom_range(15));
            lu_wdata = $urandom;
        end
        if (!md_valid || last_md) begin
            md_valid = ($urandom_range(99) < 40);
            md_rd = 5'($urandom_range(15));
            md_wdata = $urandom;
        end
        issue_long = ($urandom_range(99) < 20);
        issue_rd = 5'($urandom_range(15));
        if (issue_rd == pipe_rd_W) issue_rd = 0;
        rs1_D = 5'($urandom_range(15));
        rs2_D = 5'($urandom_range(15));
        rd_D = 5'($urandom_range(15));
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(posedge clk);
        settle();
        chk("reset_we_literal", {31'b0, we_reg_W}, 0);
        chk("reset_hold_literal", {31'b0, pipe_hold}, 0);

        // Pipe write right after reset.
        next_cycle();
        rst_n = 1;
        pipe_we_W = 1; pipe_rd_W = 5; pipe_wdata_W = 32'hDEADBEEF;
        settle();
        chk("pipe_we", {31'b0, we_reg_W}, 1);
        chk("pipe_rd", {27'b0, rd_W}, 5);
        chk("pipe_data", Wdata, 32'hDEADBEEF);
        chk("pipe_src", {30'b0, wb_src_W}, 1);
        chk("pipe_lu_ready", {31'b0, lu_ready}, 0);

        // Round-robin between LU and MD.
        next_cycle();
        pipe_we_W = 0;
        lu_valid = 1; lu_rd = 3; lu_wdata = 32'h1111_0003;
        md_valid = 1; md_rd = 4; md_wdata = 32'h2222_0004;
        settle();
        chk("rr1_lu_ready", {31'b0, lu_ready}, 1);
        chk("rr1_md_ready", {31'b0, md_ready}, 0);
        chk("rr1_rd", {27'b0, rd_W}, 3);
        next_cycle();
        lu_rd = 13; lu_wdata = 32'h1111_000D;
        settle();
        chk("rr2_md_ready", {31'b0, md_ready}, 1);
        chk("rr2_src", {30'b0, wb_src_W}, 3);
        chk("rr2_data", Wdata, 32'h2222_0004);
        next_cycle();
        md_rd = 14; md_wdata = 32'h2222_000E;
        settle();
        chk("rr3_back_to_lu", {31'b0, lu_ready}, 1);
        chk("rr3_rd", {27'b0, rd_W}, 13);
        next_cycle();
        lu_valid = 0;
        settle();
        next_cycle();
        md_valid = 0;

        // Scoreboard hazard on register 7.
        issue_long = 1; issue_rd = 7; rs1_D = 7;
        settle();
        chk("sb_not_yet", {31'b0, stall_D}, 0);
        next_cycle();
        issue_long = 0;
        settle();
        chk("sb_rs1_busy", {31'b0, stall_D}, 1);
        next_cycle();
        rs1_D = 0; rs2_D = 0; rd_D = 0;
        settle();
        chk("sb_x0_no_stall", {31'b0, stall_D}, 0);
        next_cycle();
        rs1_D = 1; rd_D = 7;
        md_valid = 1; md_rd = 7; md_wdata = 32'h7777_7777;
        settle();
        chk("sb_md_grant7", {31'b0, md_ready}, 1);
        chk("sb_stall_while_clear", {31'b0, stall_D}, 1);
        next_cycle();
        md_valid = 0;
        settle();
        chk("sb_stall_dropped", {31'b0, stall_D}, 0);

        // Same-cycle set and clear of register 9.
        next_cycle();
        rd_D = 0; rs1_D = 9;
        md_valid = 1; md_rd = 9; md_wdata = 32'h9;
        issue_long = 1; issue_rd = 9;
        settle();
        chk("coll_md_grant", {31'b0, md_ready}, 1);
        next_cycle();
        md_valid = 0; issue_long = 0;
        settle();
        chk("coll_set_wins", {31'b0, stall_D}, 1);
        next_cycle();
        md_valid = 1;
        settle();
        next_cycle();
        md_valid = 0; rs1_D = 0;

        // Starvation of LU behind a busy pipeline.
`ifdef RF_WB_STARVE_EN
        for (int k = 0; k < 8; k++) begin
            if (k != 0) next_cycle();
            pipe_we_W = 1; pipe_rd_W = 5'(k + 1); pipe_wdata_W = 32'h100 + k;
            lu_valid = 1; lu_rd = 10; lu_wdata = 32'hA0A0_A0A0;
            settle();
            chk("starve_wait_ready", {31'b0, lu_ready}, 0);
            chk("starve_wait_hold", {31'b0, pipe_hold}, 0);
        end
        next_cycle();
        settle();
        chk("starve_hold", {31'b0, pipe_hold}, 1);
        chk("starve_lu_ready", {31'b0, lu_ready}, 1);
        chk("starve_src", {30'b0, wb_src_W}, 2);
        chk("starve_rd", {27'b0, rd_W}, 10);
        next_cycle();
        lu_valid = 0;
        settle();
        chk("starve_hold_drop", {31'b0, pipe_hold}, 0);
        chk("starve_pipe_again", {30'b0, wb_src_W}, 1);
        chk("starve_pipe_rd", {27'b0, rd_W}, 8);
`else
        for (int k = 0; k < 12; k++) begin
            if (k != 0) next_cycle();
            pipe_we_W = 1; pipe_rd_W = 5'(k + 1); pipe_wdata_W = 32'h100 + k;
            lu_valid = 1; lu_rd = 10; lu_wdata = 32'hA0A0_A0A0;
            settle();
            chk("nostarve_wait_ready", {31'b0, lu_ready}, 0);
            chk("nostarve_hold", {31'b0, pipe_hold}, 0);
        end
        next_cycle();
        pipe_we_W = 0;
        settle();
        chk("nostarve_lu_ready", {31'b0, lu_ready}, 1);
        next_cycle();
        lu_valid = 0;
`endif
        next_cycle();
        pipe_we_W = 0;

        // Asynchronous reset in the middle of activity.
        issue_long = 1; issue_rd = 12;
        next_cycle();
        issue_long = 0; rs1_D = 12;
        settle();
        chk("mid_busy12", {31'b0, stall_D}, 1);
`ifdef RF_WB_STARVE_EN
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            pipe_we_W = 1; pipe_rd_W = 5'(k + 1); pipe_wdata_W = 32'h200 + k;
            lu_valid = 1; lu_rd = 11; lu_wdata = 32'hB0B0_B0B0;
        end
        next_cycle();
        chk("mid_hold_before_rst", {31'b0, pipe_hold}, 1);
`else
        next_cycle();
        pipe_we_W = 1; pipe_rd_W = 3; lu_valid = 1; lu_rd = 11;
`endif
        #2 rst_n = 0;
        #1;
        chk("async_hold", {31'b0, pipe_hold}, 0);
        chk("async_we", {31'b0, we_reg_W}, 0);
        chk("async_lu_ready", {31'b0, lu_ready}, 0);
        chk("async_md_ready", {31'b0, md_ready}, 0);
        chk("async_stall", {31'b0, stall_D}, 0);
        chk("async_src", {30'b0, wb_src_W}, 0);
        clear_inputs();
        next_cycle();
        rst_n = 1;
        rs1_D = 12;
        settle();
        chk("reset_cleared_busy12", {31'b0, stall_D}, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            drive_random(c);
        end
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
